// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin, burst-capped write arbiter for one shared W-bit enabled register.
module shared_reg_arbiter #(
    parameter int N         = 4,
    parameter int W         = 4,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       wdata,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 reg_en,
    output logic [W-1:0]         reg_d
);
    localparam int OW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d, last_q, last_d, win, idx;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          rel;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(N - 1);
            cnt_q   <= '0;
            gnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
        end
    end

    // Descending scan so the nearest requester after last_q is assigned last and wins.
    always_comb begin
        win = last_q;
        idx = '0;
        for (int k = N; k >= 1; k--) begin
            idx = OW'((int'(last_q) + k) % N);
            if (req[idx]) win = idx;
        end
    end

    assign rel = ~req[owner_q] | (reg_en & (cnt_q == CW'(MAX_BURST - 1)));

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        if (state_q == IDLE) begin
            if (|req) begin
                state_d = BUSY;
                owner_d = win;
                gnt_d   = N'(1) << win;
                cnt_d   = '0;
            end
        end else if (rel) begin
            state_d = IDLE;
            gnt_d   = '0;
            last_d  = owner_q;
            cnt_d   = '0;
        end else if (reg_en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_comb begin
        reg_en = (state_q == BUSY) & req[owner_q] & ~reset;
        reg_d  = (state_q == BUSY) ? wdata[owner_q*W +: W] : '0;
    end

    assign gnt   = gnt_q;
    assign owner = owner_q;
    assign busy  = state_q == BUSY;
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb_shared_reg_arbiter: directed scenario tasks for shared_reg_arbiter with a model of the shared register.
module tb_shared_reg_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic        reg_en;
    logic [3:0]  reg_d;
    logic [3:0]  q;
    int checks = 0;
    int errors = 0;

    shared_reg_arbiter #(.N(4), .W(4), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset), .req(req), .wdata(wdata),
        .gnt(gnt), .owner(owner), .busy(busy), .reg_en(reg_en), .reg_d(reg_d)
    );

    always #5 clk = ~clk;

    // The shared register the arbiter drives.
    always @(posedge clk) if (reg_en) q <= reg_d;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; req = '0; wdata = '0;
        tick; tick;
        checks++;
        if ({gnt, owner, busy} !== 7'b0) begin
            errors++; $display("FAIL reset_state got gnt=%b owner=%0d busy=%b exp 0/0/0", gnt, owner, busy);
        end
        checks++;
        if ({reg_en, reg_d} !== 5'b0) begin
            errors++; $display("FAIL reset_regport got en=%b d=%h exp 0/0", reg_en, reg_d);
        end
        reset = 1'b0;
    endtask

    task automatic test_single;
        req = 4'b0100; wdata[11:8] = 4'hA;
        #1;
        checks++;
        if (reg_en !== 1'b0) begin errors++; $display("FAIL single_idle_en got %b exp 0", reg_en); end
        tick;
        checks++;
        if ({gnt, owner, busy} !== {4'b0100, 2'd2, 1'b1}) begin
            errors++; $display("FAIL single_grant got gnt=%b owner=%0d busy=%b exp 0100/2/1", gnt, owner, busy);
        end
        checks++;
        if ({reg_en, reg_d} !== {1'b1, 4'hA}) begin
            errors++; $display("FAIL single_first_en got en=%b d=%h exp 1/a", reg_en, reg_d);
        end
        tick;
        checks++;
        if ({reg_en, q} !== {1'b1, 4'hA}) begin
            errors++; $display("FAIL single_second got en=%b q=%h exp 1/a", reg_en, q);
        end
        tick;
        req = '0;
        #1;
        checks++;
        if ({reg_en, gnt} !== {1'b0, 4'b0100}) begin
            errors++; $display("FAIL single_drop got en=%b gnt=%b exp 0/0100", reg_en, gnt);
        end
        tick;
        checks++;
        if ({gnt, busy, q} !== {4'b0, 1'b0, 4'hA}) begin
            errors++; $display("FAIL single_release got gnt=%b busy=%b q=%h exp 0000/0/a", gnt, busy, q);
        end
    endtask

    task automatic test_burst_cap;
        req = 4'b0010; wdata = 16'h0010;
        tick;
        for (int v = 1; v <= 4; v++) begin
            #1;
            checks++;
            if ({reg_en, reg_d, gnt} !== {1'b1, 4'(v), 4'b0010}) begin
                errors++; $display("FAIL burst_write%0d got en=%b d=%h gnt=%b exp 1/%h/0010", v, reg_en, reg_d, gnt, 4'(v));
            end
            tick;
            checks++;
            if (q !== 4'(v)) begin errors++; $display("FAIL burst_q%0d got %h exp %h", v, q, 4'(v)); end
            wdata[7:4] = 4'(v + 1);
        end
        #1;
        checks++;
        if ({gnt, busy, reg_en} !== 6'b0) begin
            errors++; $display("FAIL burst_bubble got gnt=%b busy=%b en=%b exp 0/0/0", gnt, busy, reg_en);
        end
        tick;
        checks++;
        if ({gnt, owner, q} !== {4'b0010, 2'd1, 4'h4}) begin
            errors++; $display("FAIL burst_regrant got gnt=%b owner=%0d q=%h exp 0010/1/4", gnt, owner, q);
        end
        tick;
        checks++;
        if (q !== 4'h5) begin errors++; $display("FAIL burst_fifth got %h exp 5", q); end
        req = '0;
        tick;
        checks++;
        if (gnt !== 4'b0) begin errors++; $display("FAIL burst_end got %b exp 0000", gnt); end
    endtask

    task automatic test_round_robin;
        reset = 1'b1; req = '0;
        tick;
        reset = 1'b0; req = 4'b1111; wdata = 16'hDCBA;
        for (int g = 0; g < 5; g++) begin
            tick;
            for (int w = 0; w < 4; w++) begin
                checks++;
                if ({gnt, owner, busy, reg_en, reg_d} !== {4'b0001 << (g % 4), 2'(g % 4), 1'b1, 1'b1, 4'(4'hA + g % 4)}) begin
                    errors++;
                    $display("FAIL rr_g%0d_w%0d got gnt=%b owner=%0d busy=%b en=%b d=%h exp %b/%0d/1/1/%h",
                             g, w, gnt, owner, busy, reg_en, reg_d, 4'b0001 << (g % 4), g % 4, 4'(4'hA + g % 4));
                end
                tick;
            end
            checks++;
            if ({gnt, busy, reg_en, q} !== {4'b0, 1'b0, 1'b0, 4'(4'hA + g % 4)}) begin
                errors++; $display("FAIL rr_bubble%0d got gnt=%b busy=%b en=%b q=%h exp 0000/0/0/%h", g, gnt, busy, reg_en, q, 4'(4'hA + g % 4));
            end
        end
    endtask

    task automatic test_skip_wrap;
        req = 4'b1000;
        tick;
        checks++;
        if ({gnt, owner} !== {4'b1000, 2'd3}) begin
            errors++; $display("FAIL skip_own3 got gnt=%b owner=%0d exp 1000/3", gnt, owner);
        end
        req = 4'b0101;
        tick;
        checks++;
        if (gnt !== 4'b0) begin errors++; $display("FAIL skip_rel3 got %b exp 0000", gnt); end
        tick;
        checks++;
        if ({gnt, owner} !== {4'b0001, 2'd0}) begin
            errors++; $display("FAIL wrap_to0 got gnt=%b owner=%0d exp 0001/0", gnt, owner);
        end
        req = '0;
        tick;
        req = 4'b0101;
        tick;
        checks++;
        if ({gnt, owner} !== {4'b0100, 2'd2}) begin
            errors++; $display("FAIL skip_to2 got gnt=%b owner=%0d exp 0100/2", gnt, owner);
        end
        req = '0;
        tick;
    endtask

    task automatic test_isolation;
        req = 4'b0001; wdata = 16'h0007;
        tick;
        for (int c = 0; c < 4; c++) begin
            req = (c % 2 == 1) ? 4'b0011 : 4'b0001;
            wdata[7:4] = 4'(8 + c);
            #1;
            checks++;
            if ({reg_en, reg_d, gnt} !== {1'b1, 4'h7, 4'b0001}) begin
                errors++; $display("FAIL iso_c%0d got en=%b d=%h gnt=%b exp 1/7/0001", c, reg_en, reg_d, gnt);
            end
            tick;
        end
        checks++;
        if ({gnt, q} !== {4'b0, 4'h7}) begin
            errors++; $display("FAIL iso_release got gnt=%b q=%h exp 0000/7", gnt, q);
        end
        tick;
        checks++;
        if ({gnt, owner} !== {4'b0010, 2'd1}) begin
            errors++; $display("FAIL iso_next got gnt=%b owner=%0d exp 0010/1", gnt, owner);
        end
        req = '0;
        tick;
    endtask

    task automatic test_reset_mid_burst;
        req = 4'b0100; wdata = 16'h0500;
        tick;
        tick;
        wdata[11:8] = 4'h6; reset = 1'b1;
        #1;
        checks++;
        if (reg_en !== 1'b0) begin errors++; $display("FAIL rst_mid_en got %b exp 0", reg_en); end
        tick;
        checks++;
        if ({gnt, owner, busy, q} !== {4'b0, 2'd0, 1'b0, 4'h5}) begin
            errors++; $display("FAIL rst_mid_state got gnt=%b owner=%0d busy=%b q=%h exp 0000/0/0/5", gnt, owner, busy, q);
        end
        reset = 1'b0; req = 4'b1111;
        tick;
        checks++;
        if ({gnt, owner} !== {4'b0001, 2'd0}) begin
            errors++; $display("FAIL rst_mid_regrant got gnt=%b owner=%0d exp 0001/0", gnt, owner);
        end
        req = '0;
        tick;
    endtask

    initial begin
        test_reset;
        test_single;
        test_burst_cap;
        test_round_robin;
        test_skip_wrap;
        test_isolation;
        test_reset_mid_burst;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
